// File: rtl/gc_host_req_frontend.sv
// Host request front-end for the GC-DRAM controller: in-order request queue,
// credit-checked read issue, fixed-latency read tracking and a response queue.
module gc_host_req_frontend #(
   parameter int REQ_DEPTH  = 4,
   parameter int RESP_DEPTH = 4,
   parameter int READ_LAT   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [9:0]  req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [7:0]  wr_err_cnt,
   output logic        we,
   output logic        re,
   output logic [9:0]  waddr,
   output logic [9:0]  raddr,
   output logic [63:0] data_in,
   input  logic [63:0] rd
);

   // Handshake: a transfer happens on any rising clk edge where valid and ready
   // are both high; ready never depends combinationally on valid.
   localparam int RQ_AW = $clog2(REQ_DEPTH);
   localparam int RS_AW = $clog2(RESP_DEPTH);
   localparam int TRK   = READ_LAT + 1;
   localparam int REQ_W = 75;

   logic [REQ_W-1:0] rq_mem [REQ_DEPTH];
   logic [RQ_AW-1:0] rq_wr, rq_rd;
   logic [RQ_AW:0]   rq_cnt;
   logic [64:0]      rs_mem [RESP_DEPTH];
   logic [RS_AW-1:0] rs_wr, rs_rd;
   logic [RS_AW:0]   rs_cnt;
   logic [TRK-1:0]   trk_v, trk_e;

   logic             accept, head_q, cand_valid, cand_we, cand_bad;
   logic [REQ_W-1:0] cand;
   logic [9:0]       cand_addr;
   logic [63:0]      cand_data;
   logic             credit_ok, issue, rd_issue;
   logic             rq_push, rq_pop, rs_push, rs_pop;
   logic [64:0]      rs_wdata;
   int               inflight;

   assign req_ready = !rst && (rq_cnt != (RQ_AW+1)'(REQ_DEPTH));
   assign accept    = req_valid && req_ready;
   assign head_q    = (rq_cnt != '0);

   // With an empty queue the incoming request is the candidate, so an accepted
   // request can strobe the controller in the very next cycle.
   assign cand       = head_q ? rq_mem[rq_rd] : {req_we, req_addr, req_wdata};
   assign cand_valid = head_q || accept;
   assign cand_we    = cand[74];
   assign cand_addr  = cand[73:64];
   assign cand_data  = cand[63:0];
   assign cand_bad   = (cand_addr[9:7] == 3'd0);

   always_comb begin
      inflight = 0;
      for (int i = 0; i < TRK; i++) inflight += int'(trk_v[i]);
   end

   // A read reserves its response slot at issue, so tracker exit never overflows.
   assign credit_ok = (int'(rs_cnt) + inflight) < RESP_DEPTH;
   assign issue     = cand_valid && (cand_we || credit_ok);
   assign rd_issue  = issue && !cand_we;
   assign rq_pop    = head_q && issue;
   assign rq_push   = accept && (head_q || !issue);

   assign rs_push  = trk_v[TRK-1];
   assign rs_pop   = resp_valid && resp_ready;
   assign rs_wdata = trk_e[TRK-1] ? {1'b1, 64'd0} : {1'b0, rd};

   assign resp_valid = (rs_cnt != '0);
   assign resp_rdata = resp_valid ? rs_mem[rs_rd][63:0] : 64'd0;
   assign resp_err   = resp_valid && rs_mem[rs_rd][64];

   always_ff @(posedge clk) begin
      if (rq_push) rq_mem[rq_wr] <= {req_we, req_addr, req_wdata};
      if (rs_push) rs_mem[rs_wr] <= rs_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rq_wr      <= '0;
         rq_rd      <= '0;
         rq_cnt     <= '0;
         rs_wr      <= '0;
         rs_rd      <= '0;
         rs_cnt     <= '0;
         trk_v      <= '0;
         trk_e      <= '0;
         we         <= 1'b0;
         re         <= 1'b0;
         waddr      <= '0;
         raddr      <= '0;
         data_in    <= '0;
         wr_err_cnt <= '0;
      end else begin
         if (rq_push) rq_wr <= rq_wr + 1'b1;
         if (rq_pop)  rq_rd <= rq_rd + 1'b1;
         rq_cnt <= rq_cnt + (RQ_AW+1)'(rq_push) - (RQ_AW+1)'(rq_pop);

         if (rs_push) rs_wr <= rs_wr + 1'b1;
         if (rs_pop)  rs_rd <= rs_rd + 1'b1;
         rs_cnt <= rs_cnt + (RS_AW+1)'(rs_push) - (RS_AW+1)'(rs_pop);

         trk_v <= (trk_v << 1) | TRK'(rd_issue);
         trk_e <= (trk_e << 1) | TRK'(rd_issue && cand_bad);

         we <= issue && cand_we && !cand_bad;
         re <= rd_issue && !cand_bad;
         if (issue && cand_we && !cand_bad) begin
            waddr   <= cand_addr;
            data_in <= cand_data;
         end
         if (rd_issue && !cand_bad) raddr <= cand_addr;
         if (issue && cand_we && cand_bad && wr_err_cnt != 8'hFF)
            wr_err_cnt <= wr_err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_gc_host_req_frontend.sv
// Directed bench for gc_host_req_frontend with a small controller memory model
// and an expected-response queue checked by an independent monitor.
module tb_gc_host_req_frontend;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [9:0]  req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [63:0] resp_rdata;
   logic [7:0]  wr_err_cnt;
   logic        we, re;
   logic [9:0]  waddr, raddr;
   logic [63:0] data_in;
   logic [63:0] rd = 64'd0;

   gc_host_req_frontend #(.REQ_DEPTH(4), .RESP_DEPTH(4), .READ_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .wr_err_cnt(wr_err_cnt),
      .we(we), .re(re), .waddr(waddr), .raddr(raddr),
      .data_in(data_in), .rd(rd)
   );

   // clock / reset block
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // controller stand-in: one-cycle read latency, unwritten words hold a tag
   logic [63:0] cmem [1024];
   initial for (int a = 0; a < 1024; a++) cmem[a] = 64'hC0DE_0000_0000_0000 | 64'(a);
   always @(posedge clk) begin
      if (we) cmem[waddr] <= data_in;
      if (re) rd <= cmem[raddr];
   end

   // scoreboard
   logic [64:0] exp_q[$];
   int n_chk = 0;
   int n_pass = 0;
   int acc_cyc = 0;
   int we_cnt = 0, re_cnt = 0, we_run = 0, re_run = 0, we_run_max = 0, re_run_max = 0;

   function automatic void check(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (we) begin
            we_cnt++; we_run++;
            if (we_run > we_run_max) we_run_max = we_run;
         end else we_run = 0;
         if (re) begin
            re_cnt++; re_run++;
            if (re_run > re_run_max) re_run_max = re_run;
         end else re_run = 0;
         if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL resp_unexpected: got err=%0b data=%0h with nothing expected", resp_err, resp_rdata);
            end else begin
               check("resp", {resp_err, resp_rdata}, exp_q.pop_front());
            end
         end
      end
   end

   // driver tasks (callers start just after a rising edge)
   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic w, input logic [9:0] a, input logic [63:0] d);
      int n = 0;
      req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d;
      @(negedge clk);
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      if (!req_ready) begin
         n_chk++;
         $display("FAIL send_timeout: req_ready=%0b expected 1 within 200 cycles", req_ready);
      end
      acc_cyc = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      check("idle_timeout", 65'(exp_q.size()), 65'd0);
      repeat (3) @(negedge clk);
      sync();
   endtask

   function automatic logic [9:0] ad(input int bank, input int row);
      return {3'(bank), 7'(row)};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1);
   end

   initial begin
      int base_we, base_re, re_c, rv_c, hits;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b1;

      // reset state
      @(negedge clk);
      check("rst_req_ready", 65'(req_ready), 65'd0);
      check("rst_we_re", {63'd0, we, re}, 65'd0);
      check("rst_resp_valid", 65'(resp_valid), 65'd0);
      check("rst_wr_err_cnt", 65'(wr_err_cnt), 65'd0);
      sync(); rst = 1'b0;
      @(negedge clk);
      check("rel_req_ready", 65'(req_ready), 65'd1);
      sync();

      // 7 writes then 7 reads, back to back
      base_we = we_cnt; base_re = re_cnt; we_run_max = 0; re_run_max = 0;
      for (int b = 1; b <= 7; b++) send(1'b1, ad(b, 3), 64'(200*b + 3));
      for (int b = 1; b <= 7; b++) begin
         exp_q.push_back({1'b0, 64'(200*b + 3)});
         send(1'b0, ad(b, 3), 64'd0);
      end
      wait_idle();
      check("wr_pulses", 65'(we_cnt - base_we), 65'd7);
      check("wr_consecutive", 65'(we_run_max), 65'd7);
      check("rd_pulses", 65'(re_cnt - base_re), 65'd7);
      check("rd_consecutive", 65'(re_run_max), 65'd7);

      // single read latency
      re_c = -1; rv_c = -1;
      exp_q.push_back({1'b0, 64'hC0DE_0000_0000_0209});
      send(1'b0, 10'h209, 64'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (re && re_c < 0) re_c = cyc;
         if (resp_valid && rv_c < 0) rv_c = cyc;
      end
      check("lat_re", 65'(re_c - acc_cyc), 65'd1);
      check("lat_resp", 65'(rv_c - acc_cyc), 65'd3);
      wait_idle();

      // response back-pressure: credits limit issue to 4 reads
      base_re = re_cnt; resp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back({1'b0, 64'(200*((i % 7) + 1) + 3)});
         send(1'b0, ad((i % 7) + 1, 3), 64'd0);
      end
      repeat (5) @(negedge clk);
      check("bp_re_pulses", 65'(re_cnt - base_re), 65'd4);
      sync();
      for (int i = 6; i < 8; i++) begin
         exp_q.push_back({1'b0, 64'(200*((i % 7) + 1) + 3)});
         send(1'b0, ad((i % 7) + 1, 3), 64'd0);
      end
      @(negedge clk);
      check("bp_req_ready_full", 65'(req_ready), 65'd0);
      repeat (4) @(negedge clk);
      check("bp_re_held", 65'(re_cnt - base_re), 65'd4);
      sync(); resp_ready = 1'b1;
      wait_idle();
      check("bp_re_total", 65'(re_cnt - base_re), 65'd8);

      // bank-0 accesses
      base_we = we_cnt; base_re = re_cnt;
      send(1'b1, 10'h005, 64'hDEAD_BEEF);
      repeat (3) @(negedge clk);
      check("bad_wr_cnt", 65'(wr_err_cnt), 65'd1);
      check("bad_wr_no_we", 65'(we_cnt - base_we), 65'd0);
      sync();
      exp_q.push_back({1'b0, 64'd203});  send(1'b0, ad(1, 3), 64'd0);
      exp_q.push_back({1'b1, 64'd0});    send(1'b0, 10'h005, 64'd0);
      exp_q.push_back({1'b0, 64'd403});  send(1'b0, ad(2, 3), 64'd0);
      wait_idle();
      check("bad_rd_no_re", 65'(re_cnt - base_re), 65'd2);

      // reset with responses pending and reads in flight
      resp_ready = 1'b0;
      exp_q.push_back({1'b0, 64'd803});  send(1'b0, ad(4, 3), 64'd0);
      exp_q.push_back({1'b0, 64'd1003}); send(1'b0, ad(5, 3), 64'd0);
      repeat (5) @(negedge clk);
      sync();
      exp_q.push_back({1'b0, 64'd1203}); send(1'b0, ad(6, 3), 64'd0);
      exp_q.push_back({1'b0, 64'd1403}); send(1'b0, ad(7, 3), 64'd0);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      check("mrst_we_re", {63'd0, we, re}, 65'd0);
      check("mrst_waddr", 65'(waddr), 65'd0);
      check("mrst_raddr", 65'(raddr), 65'd0);
      check("mrst_data_in", 65'(data_in), 65'd0);
      check("mrst_resp_valid", 65'(resp_valid), 65'd0);
      check("mrst_resp", {resp_err, resp_rdata}, 65'd0);
      check("mrst_wr_err_cnt", 65'(wr_err_cnt), 65'd0);
      check("mrst_req_ready", 65'(req_ready), 65'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mrst_rel_ready", 65'(req_ready), 65'd1);
      resp_ready = 1'b1;
      hits = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp_valid) hits++;
      end
      check("mrst_no_stale", 65'(hits), 65'd0);
      sync();
      exp_q.push_back({1'b0, 64'd603}); send(1'b0, ad(3, 3), 64'd0);
      wait_idle();

      // saturation of dropped-write counter
      base_we = we_cnt;
      for (int i = 0; i < 300; i++) send(1'b1, ad(0, i % 128), 64'(i));
      repeat (3) @(negedge clk);
      check("sat_wr_err_cnt", 65'(wr_err_cnt), 65'd255);
      check("sat_no_we", 65'(we_cnt - base_we), 65'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
